// File: rtl/user_jtag_pkg.sv
// Shared types and helpers for the user JTAG read register: FSM encoding and
// counter sizing.
package user_jtag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPT     = 2'd1,
        ST_SHIFTING = 2'd2,
        ST_FULL     = 2'd3
    } rd_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // The counter must be able to hold the value 'width' itself (saturation point).
    function automatic int cnt_width(input int w);
        return clog2(w + 1);
    endfunction

endpackage

// File: rtl/user_rd_reg.sv
// User JTAG data register that lets the debugger read a word posted by the
// fabric, with read acknowledge and sticky overrun detection.
module user_rd_reg
    import user_jtag_pkg::*;
#(
    parameter int               width     = 16,
    parameter logic [width-1:0] def_value = '0
) (
    input  logic             TCK,
    input  logic             RST_B,
    input  logic             FSEL,
    input  logic             SEL,
    input  logic             DSY_CHAIN,
    input  logic             TDI,
    input  logic             DSY_IN,
    input  logic             CAPTURE,
    input  logic             SHIFT,
    input  logic             UPDATE,
    input  logic [width-1:0] PI,
    input  logic             PI_STB,
    output logic             TDO,
    output logic             DSY_OUT,
    output logic             RD_ACK,
    output logic             OVERRUN
);

    localparam int             CNT_W    = cnt_width(width);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(width);

    rd_state_t        state_reg, state_next;
    logic [width-1:0] sr_reg, sr_next;
    logic [width-1:0] hold_reg, hold_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             fresh_reg, fresh_next;
    logic             overrun_reg, overrun_next;
    logic             rd_ack_reg, rd_ack_next;

    logic             en;
    logic             din;
    logic             do_cap;
    logic             do_shift;
    logic             do_update;
    logic             read_done;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge TCK or negedge RST_B) begin
        if (!RST_B) begin
            state_reg   <= ST_IDLE;
            sr_reg      <= def_value;
            hold_reg    <= def_value;
            cnt_reg     <= '0;
            fresh_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            rd_ack_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sr_reg      <= sr_next;
            hold_reg    <= hold_next;
            cnt_reg     <= cnt_next;
            fresh_reg   <= fresh_next;
            overrun_reg <= overrun_next;
            rd_ack_reg  <= rd_ack_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sr_next      = sr_reg;
        hold_next    = hold_reg;
        cnt_next     = cnt_reg;
        fresh_next   = fresh_reg;
        overrun_next = overrun_reg;
        rd_ack_next  = 1'b0;

        en  = SEL & (FSEL | DSY_CHAIN);
        din = DSY_CHAIN ? DSY_IN : TDI;

        // TAP states are mutually exclusive; if not, CAPTURE > SHIFT > UPDATE.
        do_cap    = en & CAPTURE;
        do_shift  = en & SHIFT & ~CAPTURE;
        do_update = en & UPDATE & ~CAPTURE & ~SHIFT;
        read_done = do_update & (state_reg == ST_FULL);
        cnt_inc   = (cnt_reg == CNT_FULL) ? cnt_reg : cnt_reg + CNT_W'(1);

        if (!SEL) begin
            state_next = ST_IDLE;
        end else if (do_cap) begin
            sr_next    = hold_reg;
            cnt_next   = '0;
            state_next = ST_CAPT;
        end else if (do_shift) begin
            sr_next  = {din, sr_reg[width-1:1]};
            cnt_next = cnt_inc;
            if (state_reg == ST_CAPT || state_reg == ST_SHIFTING) begin
                state_next = (cnt_inc == CNT_FULL) ? ST_FULL : ST_SHIFTING;
            end
        end else if (do_update) begin
            state_next = ST_IDLE;
        end

        rd_ack_next = read_done;

        // A strobe coinciding with the consuming UPDATE refills the slot cleanly.
        if (PI_STB) begin
            hold_next  = PI;
            fresh_next = 1'b1;
            if (fresh_reg && !read_done) begin
                overrun_next = 1'b1;
            end
        end else if (read_done) begin
            fresh_next = 1'b0;
        end
    end

    assign TDO     = FSEL & sr_reg[0];
    assign DSY_OUT = DSY_CHAIN & sr_reg[0];
    assign RD_ACK  = rd_ack_reg;
    assign OVERRUN = overrun_reg;

endmodule

// File: tb/tb_user_rd_reg.sv
// Self-checking bench for user_rd_reg: directed scenarios plus a randomized
// run against a word/bit-count level reference model.
module tb_user_rd_reg;

    logic        TCK = 1'b0;
    logic        RST_B = 1'b0;
    logic        FSEL = 1'b0;
    logic        SEL = 1'b0;
    logic        DSY_CHAIN = 1'b0;
    logic        TDI = 1'b0;
    logic        DSY_IN = 1'b0;
    logic        CAPTURE = 1'b0;
    logic        SHIFT = 1'b0;
    logic        UPDATE = 1'b0;
    logic [15:0] PI = '0;
    logic        PI_STB = 1'b0;
    logic        TDO;
    logic        DSY_OUT;
    logic        RD_ACK;
    logic        OVERRUN;

    user_rd_reg #(.width(16), .def_value(16'h0000)) dut (
        .TCK(TCK), .RST_B(RST_B), .FSEL(FSEL), .SEL(SEL), .DSY_CHAIN(DSY_CHAIN),
        .TDI(TDI), .DSY_IN(DSY_IN), .CAPTURE(CAPTURE), .SHIFT(SHIFT), .UPDATE(UPDATE),
        .PI(PI), .PI_STB(PI_STB), .TDO(TDO), .DSY_OUT(DSY_OUT), .RD_ACK(RD_ACK),
        .OVERRUN(OVERRUN)
    );

    always #5 TCK = ~TCK;

    int total = 0;
    int bad = 0;

    logic obs_tdo, obs_dsy, obs_ack, obs_ovr;
    logic exp_tdo, exp_dsy;

    // Reference model: the word being read, how many bits have been clocked
    // out since the last capture, and whether a read session is open.
    logic [15:0] m_sr, m_hold;
    logic        m_fresh, m_ovr, m_ack, m_in_read;
    int          m_cnt;

    task automatic model_reset();
        m_sr = 16'h0000; m_hold = 16'h0000;
        m_fresh = 1'b0; m_ovr = 1'b0; m_ack = 1'b0; m_in_read = 1'b0;
        m_cnt = 0;
    endtask

    // One TCK cycle; called and returns at posedge+1.
    task automatic step(input logic sel, input logic fsel, input logic dsy,
                        input logic tdi, input logic dsy_in, input logic cap,
                        input logic sh, input logic upd, input logic stb,
                        input logic [15:0] pi);
        logic en, din, completing;
        SEL = sel; FSEL = fsel; DSY_CHAIN = dsy; TDI = tdi; DSY_IN = dsy_in;
        CAPTURE = cap; SHIFT = sh; UPDATE = upd; PI_STB = stb; PI = pi;
        #1;
        obs_tdo = TDO;
        obs_dsy = DSY_OUT;
        exp_tdo = fsel & m_sr[0];
        exp_dsy = dsy & m_sr[0];

        en = sel & (fsel | dsy);
        din = dsy ? dsy_in : tdi;
        completing = 1'b0;
        if (!sel) begin
            m_in_read = 1'b0;
        end else if (en && cap) begin
            m_sr = m_hold; m_cnt = 0; m_in_read = 1'b1;
        end else if (en && sh) begin
            m_sr = {din, m_sr[15:1]};
            if (m_cnt < 16) m_cnt = m_cnt + 1;
        end else if (en && upd) begin
            completing = m_in_read && (m_cnt >= 16);
            m_in_read = 1'b0;
        end
        if (stb) begin
            if (m_fresh && !completing) m_ovr = 1'b1;
            m_hold = pi; m_fresh = 1'b1;
        end else if (completing) begin
            m_fresh = 1'b0;
        end
        m_ack = completing;

        @(posedge TCK);
        #1;
        obs_ack = RD_ACK;
        obs_ovr = OVERRUN;
    endtask

    task automatic apply_reset();
        RST_B = 1'b0;
        SEL = 0; CAPTURE = 0; SHIFT = 0; UPDATE = 0; PI_STB = 0; TDI = 0; DSY_IN = 0;
        FSEL = 1'b1; DSY_CHAIN = 1'b1;
        #2;
        obs_tdo = TDO; obs_dsy = DSY_OUT; obs_ack = RD_ACK; obs_ovr = OVERRUN;
        model_reset();
        repeat (2) @(posedge TCK);
        #1;
        RST_B = 1'b1; FSEL = 1'b0; DSY_CHAIN = 1'b0;
    endtask

    task automatic do_read(input logic fsel, input logic dsy, output logic [15:0] data);
        data = '0;
        step(1, fsel, dsy, 0, 0, 1, 0, 0, 0, 16'h0);
        for (int i = 0; i < 16; i++) begin
            step(1, fsel, dsy, 0, 0, 0, 1, 0, 0, 16'h0);
            data[i] = fsel ? obs_tdo : obs_dsy;
        end
        step(1, fsel, dsy, 0, 0, 0, 0, 1, 0, 16'h0);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (obs_tdo !== 1'b0) begin bad++; $display("FAIL reset_tdo got=%b want=0", obs_tdo); end
        total++; if (obs_dsy !== 1'b0) begin bad++; $display("FAIL reset_dsy got=%b want=0", obs_dsy); end
        total++; if (obs_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", obs_ack); end
        total++; if (obs_ovr !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", obs_ovr); end
        step(1, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0);
        total++; if (obs_ack !== 1'b0) begin bad++; $display("FAIL reset_idle_update_ack got=%b want=0", obs_ack); end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        logic [15:0] word;
        word = 16'hA5C3;
        apply_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, word);
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 16'h0);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 0, 1'($urandom_range(0, 1)), 0, 0, 1, 0, 0, 16'h0);
            total++;
            if (obs_tdo !== word[i]) begin
                bad++; $display("FAIL basic_tdo bit=%0d got=%b want=%b", i, obs_tdo, word[i]);
            end
        end
        total++; if (obs_ack !== 1'b0) begin bad++; $display("FAIL basic_ack_early got=%b want=0", obs_ack); end
        step(1, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0);
        total++; if (obs_ack !== 1'b1) begin bad++; $display("FAIL basic_ack got=%b want=1", obs_ack); end
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        total++; if (obs_ack !== 1'b0) begin bad++; $display("FAIL basic_ack_pulse got=%b want=0", obs_ack); end
        // Slot was consumed, so a new strobe must not flag overrun.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0F0F);
        total++; if (obs_ovr !== 1'b0) begin bad++; $display("FAIL basic_fresh_cleared ovr=%b want=0", obs_ovr); end
        $display("test_basic: read 0x%04h", word);
    endtask

    task automatic test_overrun();
        logic [15:0] data;
        apply_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h1234);
        total++; if (obs_ovr !== 1'b0) begin bad++; $display("FAIL ovr_first got=%b want=0", obs_ovr); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h5678);
        total++; if (obs_ovr !== 1'b1) begin bad++; $display("FAIL ovr_second got=%b want=1", obs_ovr); end
        do_read(1, 0, data);
        total++; if (data !== 16'h5678) begin bad++; $display("FAIL ovr_data got=%h want=5678", data); end
        total++; if (obs_ack !== 1'b1) begin bad++; $display("FAIL ovr_ack got=%b want=1", obs_ack); end
        total++; if (obs_ovr !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", obs_ovr); end
        $display("test_overrun: read 0x%04h", data);
    endtask

    task automatic test_partial();
        logic [15:0] word, data;
        word = 16'($urandom);
        apply_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, word);
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 16'h0);
        repeat (8) step(1, 1, 0, 1, 0, 0, 1, 0, 0, 16'h0);
        step(1, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0);
        total++; if (obs_ack !== 1'b0) begin bad++; $display("FAIL partial_ack got=%b want=0", obs_ack); end
        do_read(1, 0, data);
        total++; if (data !== word) begin bad++; $display("FAIL partial_reread got=%h want=%h", data, word); end
        total++; if (obs_ack !== 1'b1) begin bad++; $display("FAIL partial_reread_ack got=%b want=1", obs_ack); end
        $display("test_partial: reread 0x%04h", data);
    endtask

    task automatic test_daisy();
        logic want;
        apply_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h00FF);
        step(1, 0, 1, 0, 1, 1, 0, 0, 0, 16'h0);
        for (int k = 0; k < 32; k++) begin
            step(1, 0, 1, 0, 1, 0, 1, 0, 0, 16'h0);
            want = (k < 8) ? 1'b1 : ((k < 16) ? 1'b0 : 1'b1);
            total++;
            if (obs_dsy !== want) begin bad++; $display("FAIL daisy_out k=%0d got=%b want=%b", k, obs_dsy, want); end
            total++;
            if (obs_tdo !== 1'b0) begin bad++; $display("FAIL daisy_tdo k=%0d got=%b want=0", k, obs_tdo); end
        end
        $display("test_daisy: 32 shifts");
    endtask

    task automatic test_update_strobe();
        logic [15:0] data;
        apply_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h1111);
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 16'h0);
        repeat (16) step(1, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0);
        step(1, 1, 0, 0, 0, 0, 0, 1, 1, 16'hBEEF);
        total++; if (obs_ack !== 1'b1) begin bad++; $display("FAIL updstb_ack got=%b want=1", obs_ack); end
        total++; if (obs_ovr !== 1'b0) begin bad++; $display("FAIL updstb_ovr got=%b want=0", obs_ovr); end
        do_read(1, 0, data);
        total++; if (data !== 16'hBEEF) begin bad++; $display("FAIL updstb_data got=%h want=beef", data); end
        total++; if (obs_ack !== 1'b1) begin bad++; $display("FAIL updstb_ack2 got=%b want=1", obs_ack); end
        $display("test_update_strobe: read 0x%04h", data);
    endtask

    task automatic test_reset_mid();
        logic [15:0] word;
        word = 16'($urandom) | 16'h0021;
        apply_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, word);
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 16'h0);
        repeat (5) step(1, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0);
        apply_reset();
        total++; if (obs_tdo !== 1'b0) begin bad++; $display("FAIL rstmid_tdo got=%b want=0", obs_tdo); end
        total++; if (obs_ovr !== 1'b0) begin bad++; $display("FAIL rstmid_ovr got=%b want=0", obs_ovr); end
        repeat (11) step(1, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0);
        step(1, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0);
        total++; if (obs_ack !== 1'b0) begin bad++; $display("FAIL rstmid_ack got=%b want=0", obs_ack); end
        $display("test_reset_mid: aborted read of 0x%04h", word);
    endtask

    task automatic test_random();
        int acks;
        acks = 0;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 19) == 0), 16'($urandom));
            total++; if (obs_tdo !== exp_tdo) begin bad++; $display("FAIL rand_tdo n=%0d got=%b want=%b", n, obs_tdo, exp_tdo); end
            total++; if (obs_dsy !== exp_dsy) begin bad++; $display("FAIL rand_dsy n=%0d got=%b want=%b", n, obs_dsy, exp_dsy); end
            total++; if (obs_ack !== m_ack) begin bad++; $display("FAIL rand_ack n=%0d got=%b want=%b", n, obs_ack, m_ack); end
            total++; if (obs_ovr !== m_ovr) begin bad++; $display("FAIL rand_ovr n=%0d got=%b want=%b", n, obs_ovr, m_ovr); end
            if (m_ack) acks++;
        end
        $display("test_random: 400 cycles, %0d completed reads", acks);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overrun();
        test_partial();
        test_daisy();
        test_update_strobe();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/user_rd_reg.md
USER_RD_REG -- requirements
Module: user_rd_reg

Interface
REQ-001 SHALL have parameter width, default 16, meaning the number of bits in the shift and holding registers.
REQ-002 SHALL have parameter def_value, default 16'h0000, meaning the reset value of the shift and holding registers.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, exactly as follows: TCK  input  1  sole clock, all logic on rising edge.
REQ-004 RST_B  input  1  asynchronous active-low reset.
REQ-005 FSEL  input  1  function select (standalone mode).
REQ-006 SEL  input  1  user JTAG instruction active.
REQ-007 DSY_CHAIN  input  1  daisy-chain mode.
REQ-008 TDI  input  1  serial data in (standalone mode).
REQ-009 DSY_IN  input  1  serial data in (daisy mode).
REQ-010 CAPTURE  input  1  Capture-DR state.
REQ-011 SHIFT  input  1  Shift-DR state.
REQ-012 UPDATE  input  1  Update-DR state.
REQ-013 PI  input  width  parallel data from fabric, same clock domain.
REQ-014 PI_STB  input  1  one-cycle strobe that PI is valid.
REQ-015 TDO  output  1  FSEL & sr[0], combinational.
REQ-016 DSY_OUT  output  1  DSY_CHAIN & sr[0], combinational.
REQ-017 RD_ACK  output  1  registered one-cycle pulse when a complete read is consumed.
REQ-018 OVERRUN  output  1  registered sticky flag for unread data that was overwritten.

Function
REQ-019 en = SEL & (FSEL | DSY_CHAIN); din = DSY_CHAIN ? DSY_IN : TDI.
REQ-020 PI_STB: hold <= PI, fresh <= 1; if fresh was already 1, OVERRUN <= 1.
REQ-021 CAPTURE & en: sr <= hold, cnt <= 0, state -> CAPT, from any state.
REQ-022 CAPTURE and PI_STB in the same cycle: sr takes the old hold; hold takes PI.
REQ-023 SHIFT & en: sr <= {din, sr[width-1:1]} (LSB first); cnt increments and saturates at width.
REQ-024 FSM states are IDLE, CAPT, SHIFTING and FULL.
REQ-025 FSM transitions: CAPT -> SHIFTING on the first shift; SHIFTING -> FULL when cnt reaches width.
REQ-026 UPDATE & en in FULL: state -> IDLE, RD_ACK = 1 on the next cycle, fresh <= 0 unless PI_STB in the same cycle (PI_STB wins, fresh stays 1, no overrun).
REQ-027 UPDATE & en in CAPT or SHIFTING (partial read): state -> IDLE, no RD_ACK, fresh unchanged.
REQ-028 SEL = 0 in any non-IDLE state: state -> IDLE, no RD_ACK, sr and cnt hold.
REQ-029 CAPTURE, SHIFT and UPDATE ignored when en = 0; sr holds.
REQ-030 Simultaneous CAPTURE/SHIFT/UPDATE is illegal per the TAP; priority is CAPTURE > SHIFT > UPDATE.
REQ-031 OVERRUN clears only on reset.
REQ-032 Shifts beyond width continue shifting; the FULL state is retained.

Reset
REQ-033 RST_B low, asynchronously: sr = hold = def_value, fresh = 0, cnt = 0, state = IDLE, RD_ACK = 0, OVERRUN = 0.
REQ-034 Reset asserted mid-shift SHALL abort the read with no RD_ACK after release.
REQ-035 TDO and DSY_OUT reflect def_value[0] while reset is asserted.

Structure
REQ-036 Package user_jtag_pkg SHALL hold the FSM state enum and a cnt-width function clog2(width+1).
REQ-037 The block SHALL be a single module; no sub-module.

Verification (width = 16, def_value = 16'h0000)
REQ-038 PI = 16'hA5C3 strobe, CAPTURE, 16 SHIFTs, UPDATE with FSEL = 1 -> TDO LSB-first is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; RD_ACK pulses once; fresh = 0.
REQ-039 Strobe 16'h1234, then strobe 16'h5678 with no read -> OVERRUN = 1 and a subsequent read returns 16'h5678.
REQ-040 CAPTURE, 8 SHIFTs, UPDATE -> no RD_ACK; a re-read of 16 bits returns the same data and RD_ACK pulses.
REQ-041 DSY_CHAIN = 1, FSEL = 0, DSY_IN = 1 over 32 shifts after capturing 16'h00FF -> DSY_OUT emits 8 ones, 8 zeros, then 16 ones; TDO = 0 throughout.
REQ-042 PI_STB with 16'hBEEF on the same cycle as the completing UPDATE -> RD_ACK = 1, OVERRUN = 0, and the next read returns 16'hBEEF.
REQ-043 RST_B low at shift 5 -> TDO = 0, state IDLE, no RD_ACK after release.
